// File: rtl/game_pkg.sv
// Shared definitions for the memorization game: round-state encoding and
// the BCD digit sanitizer reused by the display driver and entry logic.
package game_pkg;

   localparam int unsigned DIGIT_MAX = 9;
   localparam int unsigned DIGIT_W   = 4;
   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned VALUE_W   = DIGIT_W * NUM_DIGITS;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHOW   = 2'd1;
   localparam logic [1:0] ST_ENTRY  = 2'd2;
   localparam logic [1:0] ST_RESULT = 2'd3;

   // Fold a raw nibble into 0..9 by dropping one decade when it overflows.
   function automatic logic [DIGIT_W-1:0] sanitizeNibble(input logic [DIGIT_W-1:0] n);
      return (n > DIGIT_W'(DIGIT_MAX)) ? n - DIGIT_W'(10) : n;
   endfunction

   function automatic logic [VALUE_W-1:0] sanitize(input logic [VALUE_W-1:0] v);
      logic [VALUE_W-1:0] r;
      r = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         r[i*DIGIT_W +: DIGIT_W] = sanitizeNibble(v[i*DIGIT_W +: DIGIT_W]);
      end
      return r;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that measures each game phase; parks at zero.
module phase_timer #(
   parameter int unsigned TIMER_W = 32
) (
   input  logic               fastClk,
   input  logic               rst,
   input  logic               load,
   input  logic [TIMER_W-1:0] loadValue,
   output logic [TIMER_W-1:0] value,
   output logic               isZero_c
);

   always_ff @(posedge fastClk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= loadValue;
      end else if (value != '0) begin
         value <= value - TIMER_W'(1);
      end
   end

   assign isZero_c = (value == '0);

endmodule

// File: rtl/game_sequencer.sv
// Round controller: shows a target, opens a timed entry window, judges the
// submission and either advances the level or returns to idle.
module game_sequencer
   import game_pkg::*;
#(
   parameter int unsigned TIMER_W         = 32,
   parameter int unsigned SHOW_CYCLES     = 200000000,
   parameter int unsigned LEVEL_STEP      = 25000000,
   parameter int unsigned MIN_SHOW_CYCLES = 50000000,
   parameter int unsigned ENTRY_TIMEOUT   = 1000000000,
   parameter int unsigned RESULT_CYCLES   = 150000000,
   parameter int unsigned MAX_LEVEL       = 15
) (
   input  logic        fastClk,
   input  logic        rst,
   input  logic        startPulse,
   input  logic        submitPulse,
   input  logic [15:0] randIn,
   input  logic [15:0] userInput,
   output logic        displayPhase,
   output logic        inputReady,
   output logic        correct,
   output logic [15:0] randInt,
   output logic        entryEnable,
   output logic        clearEntry,
   output logic [3:0]  level,
   output logic [7:0]  score
);

   localparam int unsigned PROD_W = TIMER_W + 4;

   logic [1:0]         state;
   logic [1:0]         nextState;
   logic               timerLoad;
   logic [TIMER_W-1:0] timerLoadVal;
   logic [TIMER_W-1:0] timerValue;
   logic               timerZero;
   logic [3:0]         levelNext;
   logic [7:0]         scoreNext;
   logic [15:0]        randNext;
   logic               correctNext;
   logic               clearNext;

   // Display length shrinks per level down to a floor; guarded so nothing wraps.
   function automatic logic [TIMER_W-1:0] showLenFor(input logic [3:0] lv);
      logic [PROD_W-1:0] prod;
      logic [PROD_W-1:0] len;
      prod = PROD_W'(lv) * PROD_W'(LEVEL_STEP);
      if (prod >= PROD_W'(SHOW_CYCLES)) begin
         len = PROD_W'(MIN_SHOW_CYCLES);
      end else begin
         len = PROD_W'(SHOW_CYCLES) - prod;
         if (len < PROD_W'(MIN_SHOW_CYCLES)) len = PROD_W'(MIN_SHOW_CYCLES);
      end
      return TIMER_W'(len);
   endfunction

   phase_timer #(.TIMER_W(TIMER_W)) phaseTimer (
      .fastClk   (fastClk),
      .rst       (rst),
      .load      (timerLoad),
      .loadValue (timerLoadVal),
      .value     (timerValue),
      .isZero_c  (timerZero)
   );

   always_ff @(posedge fastClk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState    = state;
      timerLoad    = 1'b0;
      timerLoadVal = '0;
      levelNext    = level;
      scoreNext    = score;
      randNext     = randInt;
      correctNext  = correct;
      clearNext    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (startPulse) begin
               nextState    = ST_SHOW;
               levelNext    = 4'd0;
               scoreNext    = 8'd0;
               randNext     = sanitize(randIn);
               timerLoad    = 1'b1;
               timerLoadVal = showLenFor(4'd0) - TIMER_W'(1);
            end
         end
         ST_SHOW: begin
            if (timerZero) begin
               nextState    = ST_ENTRY;
               clearNext    = 1'b1;
               timerLoad    = 1'b1;
               timerLoadVal = TIMER_W'(ENTRY_TIMEOUT - 1);
            end
         end
         ST_ENTRY: begin
            // A submit on the timeout cycle still gets judged.
            if (submitPulse || timerZero) begin
               nextState    = ST_RESULT;
               correctNext  = submitPulse && (userInput == randInt);
               timerLoad    = 1'b1;
               timerLoadVal = TIMER_W'(RESULT_CYCLES - 1);
            end
         end
         default: begin
            if (timerZero) begin
               if (correct) begin
                  nextState    = ST_SHOW;
                  scoreNext    = (score == 8'hFF) ? score : score + 8'd1;
                  levelNext    = (level >= 4'(MAX_LEVEL)) ? level : level + 4'd1;
                  randNext     = sanitize(randIn);
                  timerLoad    = 1'b1;
                  timerLoadVal = showLenFor(levelNext) - TIMER_W'(1);
               end else begin
                  nextState = ST_IDLE;
               end
            end
         end
      endcase
   end

   // Phase flags are registered from the upcoming state so they track it exactly.
   always_ff @(posedge fastClk or posedge rst) begin
      if (rst) begin
         displayPhase <= 1'b0;
         inputReady   <= 1'b0;
         entryEnable  <= 1'b0;
         clearEntry   <= 1'b0;
         correct      <= 1'b0;
         randInt      <= '0;
         level        <= '0;
         score        <= '0;
      end else begin
         displayPhase <= (nextState == ST_SHOW);
         inputReady   <= (nextState == ST_RESULT);
         entryEnable  <= (nextState == ST_ENTRY);
         clearEntry   <= clearNext;
         correct      <= correctNext;
         randInt      <= randNext;
         level        <= levelNext;
         score        <= scoreNext;
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed round-by-round bench for game_sequencer with small timing parameters.
module tb_game_sequencer;

   localparam int unsigned SHOW  = 20;
   localparam int unsigned STEP  = 4;
   localparam int unsigned MINS  = 8;
   localparam int unsigned ETO   = 50;
   localparam int unsigned RES   = 5;
   localparam int unsigned MAXL  = 3;

   logic        fastClk = 1'b0;
   logic        rst = 1'b1;
   logic        startPulse = 1'b0;
   logic        submitPulse = 1'b0;
   logic [15:0] randIn = 16'h0;
   logic [15:0] userInput = 16'h0;
   logic        displayPhase;
   logic        inputReady;
   logic        correct;
   logic [15:0] randInt;
   logic        entryEnable;
   logic        clearEntry;
   logic [3:0]  level;
   logic [7:0]  score;

   int          nAsserts = 0;
   int          nFails = 0;
   int          modelLevel = 0;
   int          modelScore = 0;
   logic [15:0] modelTarget = 16'h0;

   game_sequencer #(
      .TIMER_W(32), .SHOW_CYCLES(SHOW), .LEVEL_STEP(STEP), .MIN_SHOW_CYCLES(MINS),
      .ENTRY_TIMEOUT(ETO), .RESULT_CYCLES(RES), .MAX_LEVEL(MAXL)
   ) dut (
      .fastClk(fastClk), .rst(rst), .startPulse(startPulse), .submitPulse(submitPulse),
      .randIn(randIn), .userInput(userInput), .displayPhase(displayPhase),
      .inputReady(inputReady), .correct(correct), .randInt(randInt),
      .entryEnable(entryEnable), .clearEntry(clearEntry), .level(level), .score(score)
   );

   always #5 fastClk = ~fastClk;

   // Reference digit folding done with decimal-style arithmetic on each digit.
   function automatic logic [15:0] refSanitize(input logic [15:0] v);
      int r;
      int d;
      r = 0;
      for (int i = 0; i < 4; i++) begin
         d = (int'(v) / (16 ** i)) % 16;
         if (d > 9) d = d - 10;
         r = r + d * (16 ** i);
      end
      return 16'(r);
   endfunction

   function automatic int refShowLen(input int lv);
      int s;
      s = int'(SHOW) - lv * int'(STEP);
      return (s < int'(MINS)) ? int'(MINS) : s;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge fastClk);
      #1;
   endtask

   function automatic logic [63:0] allOutputs();
      return 64'({displayPhase, inputReady, correct, randInt, entryEnable, clearEntry, level, score});
   endfunction

   task automatic startRound(input logic [15:0] r);
      randIn = r;
      startPulse = 1'b1;
      tick();
      startPulse = 1'b0;
      modelLevel = 0;
      modelScore = 0;
      modelTarget = refSanitize(r);
      check("start_display", 64'(displayPhase), 64'd1);
      check("start_level", 64'(level), 64'd0);
      check("start_score", 64'(score), 64'd0);
      check("start_target", 64'(randInt), 64'(modelTarget));
   endtask

   // Count display cycles; optionally poke start/submit mid-show.
   task automatic runShow(input bit inject);
      int cnt;
      cnt = 0;
      while (displayPhase === 1'b1 && cnt < 200) begin
         if (inject && cnt == 3) begin
            startPulse = 1'b1;
            submitPulse = 1'b1;
            userInput = modelTarget;
            randIn = 16'h9999;
         end
         tick();
         startPulse = 1'b0;
         submitPulse = 1'b0;
         cnt++;
      end
      check("show_len", 64'(cnt), 64'(refShowLen(modelLevel)));
      check("show_target_stable", 64'(randInt), 64'(modelTarget));
      check("show_level_stable", 64'({level, score}), 64'({4'(modelLevel), 8'(modelScore)}));
      check("entry_clear_first", 64'({clearEntry, entryEnable, inputReady}), 64'b110);
      tick();
      check("entry_clear_once", 64'({clearEntry, entryEnable}), 64'b01);
   endtask

   task automatic runResult(input bit expC);
      int cnt;
      bit stable;
      cnt = 0;
      stable = 1'b1;
      while (inputReady === 1'b1 && cnt < 200) begin
         if (correct !== expC || entryEnable !== 1'b0) stable = 1'b0;
         tick();
         cnt++;
      end
      check("result_len", 64'(cnt), 64'(RES));
      check("result_stable", 64'(stable), 64'd1);
      if (expC) begin
         modelScore = (modelScore >= 255) ? 255 : modelScore + 1;
         modelLevel = (modelLevel >= int'(MAXL)) ? int'(MAXL) : modelLevel + 1;
         modelTarget = refSanitize(randIn);
         check("win_display", 64'(displayPhase), 64'd1);
         check("win_target", 64'(randInt), 64'(modelTarget));
      end else begin
         check("lose_idle", 64'({displayPhase, inputReady, entryEnable, correct}), 64'd0);
      end
      check("post_level", 64'(level), 64'(modelLevel));
      check("post_score", 64'(score), 64'(modelScore));
   endtask

   task automatic submitAndResult(input logic [15:0] ui, input bit expC, input logic [15:0] nextRand);
      userInput = ui;
      randIn = nextRand;
      submitPulse = 1'b1;
      tick();
      submitPulse = 1'b0;
      check("submit_result", 64'({inputReady, entryEnable, correct}), 64'({1'b1, 1'b0, expC}));
      runResult(expC);
   endtask

   task automatic checkIdleAfterReset(input string tag);
      bit bad;
      bad = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (clearEntry !== 1'b0 || displayPhase !== 1'b0 || entryEnable !== 1'b0) bad = 1'b1;
      end
      check(tag, 64'(bad), 64'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      check("reset_outputs", allOutputs(), 64'd0);
      rst = 1'b0;
      tick();
      check("idle_outputs", allOutputs(), 64'd0);

      // Sanitized target, level-0 show length, single clear pulse
      startRound(16'h1A3F);
      check("sanitize_1A3F", 64'(randInt), 64'h1035);
      runShow(1'b0);

      // First win, then a level-1 round with ignored start/submit during show
      submitAndResult(16'h1035, 1'b1, 16'($urandom));
      runShow(1'b1);

      // Keep winning until the level saturates and show hits its floor
      for (int i = 0; i < 4; i++) begin
         submitAndResult(modelTarget, 1'b1, 16'($urandom));
         runShow(1'b0);
      end
      check("sat_level", 64'(level), 64'(MAXL));
      check("sat_score", 64'(score), 64'd5);

      // Submit exactly on the last entry cycle still counts
      repeat (ETO - 2) tick();
      check("last_entry_cycle", 64'(entryEnable), 64'd1);
      submitAndResult(modelTarget, 1'b1, 16'($urandom));
      runShow(1'b0);

      // Wrong submission ends the game with level/score held
      submitAndResult(modelTarget ^ 16'h0001, 1'b0, 16'($urandom));
      repeat (5) tick();
      check("held_after_loss", 64'({level, score}), 64'({4'(MAXL), 8'd6}));

      // Timeout path after one win
      startRound(16'($urandom));
      runShow(1'b0);
      submitAndResult(modelTarget, 1'b1, 16'($urandom));
      runShow(1'b0);
      begin
         int cnt;
         cnt = 1;
         while (entryEnable === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
         end
         check("entry_timeout_len", 64'(cnt), 64'(ETO));
         check("timeout_result", 64'({inputReady, correct}), 64'b10);
      end
      runResult(1'b0);
      startRound(16'($urandom));

      // Asynchronous reset mid-show
      repeat (4) tick();
      #2 rst = 1'b1;
      #1 check("rst_mid_show", allOutputs(), 64'd0);
      repeat (2) tick();
      #2 rst = 1'b0;
      checkIdleAfterReset("idle_after_show_rst");

      // Asynchronous reset mid-result
      startRound(16'($urandom));
      runShow(1'b0);
      submitAndResult(modelTarget ^ 16'h0010, 1'b0, 16'h0);
      startRound(16'($urandom));
      runShow(1'b0);
      userInput = modelTarget;
      submitPulse = 1'b1;
      tick();
      submitPulse = 1'b0;
      tick();
      check("pre_rst_result", 64'({inputReady, correct}), 64'b11);
      #2 rst = 1'b1;
      #1 check("rst_mid_result", allOutputs(), 64'd0);
      repeat (2) tick();
      #2 rst = 1'b0;
      checkIdleAfterReset("idle_after_result_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
